// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter sequencer: letter codes, the
// pattern/length ROM and the controller state encoding.
package morse_pkg;

   localparam int PATTERN_W = 14;

   localparam logic [2:0] LTR_S = 3'd0;
   localparam logic [2:0] LTR_T = 3'd1;
   localparam logic [2:0] LTR_U = 3'd2;
   localparam logic [2:0] LTR_V = 3'd3;
   localparam logic [2:0] LTR_W = 3'd4;
   localparam logic [2:0] LTR_X = 3'd5;
   localparam logic [2:0] LTR_Y = 3'd6;
   localparam logic [2:0] LTR_Z = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_PLAY = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Unit pattern, MSB first, left-justified so the first unit sits in bit 13.
   function automatic logic [PATTERN_W-1:0] pattern_of(input logic [2:0] letter);
      logic [PATTERN_W-1:0] pat;
      case (letter)
         LTR_S:   pat = 14'b10101000000000;
         LTR_T:   pat = 14'b11100000000000;
         LTR_U:   pat = 14'b10101110000000;
         LTR_V:   pat = 14'b10101011100000;
         LTR_W:   pat = 14'b10111011100000;
         LTR_X:   pat = 14'b11101010111000;
         LTR_Y:   pat = 14'b11101011101110;
         LTR_Z:   pat = 14'b11101110101000;
         default: pat = 14'b00000000000000;
      endcase
      return pat;
   endfunction

   // Number of units in each letter's pattern.
   function automatic logic [3:0] length_of(input logic [2:0] letter);
      logic [3:0] len;
      case (letter)
         LTR_S:   len = 4'd5;
         LTR_T:   len = 4'd3;
         LTR_U:   len = 4'd7;
         LTR_V:   len = 4'd9;
         LTR_W:   len = 4'd9;
         LTR_X:   len = 4'd11;
         LTR_Y:   len = 4'd13;
         LTR_Z:   len = 4'd11;
         default: len = 4'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/morse_fifo.sv
// Letter queue: DEPTH x 3-bit FIFO with flush and registered full/empty.
// A push into a full queue is taken only when a pop happens the same cycle.
module morse_fifo
   import morse_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_push,
   input  logic [2:0] i_data,
   input  logic       i_pop,
   input  logic       i_flush,
   output logic [2:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [2:0]    r_mem [0:DEPTH-1];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_full;
   logic          r_empty;
   logic          w_pop_ok;
   logic          w_push_ok;

   assign w_pop_ok  = i_pop & ~r_empty;
   assign w_push_ok = i_push & (~r_full | w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;

   // Occupancy after this cycle's push/pop/flush.
   always_comb begin
      w_count_nxt = r_count;
      if (i_flush) begin
         w_count_nxt = {CW{1'b0}};
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == {CW{1'b0}});
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge i_clock) begin
      if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/morse_sequencer.sv
// Message-level Morse controller: plays queued letters one unit per prescaler
// tick, inserts a fixed zero gap after each letter and pulses done at the end.
module morse_sequencer
   import morse_pkg::*;
#(
   parameter int TICK_DIV  = 25_000_000,
   parameter int DEPTH     = 8,
   parameter int GAP_UNITS = 3
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_wr_en,
   input  logic [2:0] i_wr_letter,
   input  logic       i_start,
   input  logic       i_abort,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_out
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int GW = $clog2(GAP_UNITS + 1);
   localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_UNITS);

   state_t                 r_state, w_state_nxt;
   logic [PATTERN_W-1:0]   r_sreg, w_sreg_nxt;
   logic [3:0]             r_bitcnt, w_bitcnt_nxt;
   logic [GW-1:0]          r_gapcnt, w_gapcnt_nxt;
   logic [PW-1:0]          r_presc, w_presc_nxt;
   logic                   w_tick;
   logic                   w_pop;
   logic                   w_flush;
   logic                   w_push;
   logic                   w_fifo_empty;
   logic [2:0]             w_head;
   logic                   r_out, r_busy, r_done;

   // A push coinciding with abort is discarded along with the queue.
   assign w_push = i_wr_en & ~i_abort;
   assign w_tick = (r_presc == {PW{1'b0}});

   morse_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  (i_wr_letter),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_head),
      .o_full  (o_full),
      .o_empty (w_fifo_empty)
   );

   assign o_empty = w_fifo_empty;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_out   = r_out;

   // Next-state, datapath updates and queue control; abort overrides all.
   always_comb begin
      w_state_nxt  = r_state;
      w_sreg_nxt   = r_sreg;
      w_bitcnt_nxt = r_bitcnt;
      w_gapcnt_nxt = r_gapcnt;
      w_pop        = 1'b0;
      w_flush      = 1'b0;
      if (w_tick) w_presc_nxt = PRESC_RELOAD;
      else        w_presc_nxt = r_presc - PW'(1);

      case (r_state)
         ST_IDLE: begin
            if (i_start && !w_fifo_empty) w_state_nxt = ST_LOAD;
            else                          w_state_nxt = ST_IDLE;
         end
         ST_LOAD: begin
            w_pop        = 1'b1;
            w_sreg_nxt   = pattern_of(w_head);
            w_bitcnt_nxt = length_of(w_head);
            w_presc_nxt  = PRESC_RELOAD;
            w_state_nxt  = ST_PLAY;
         end
         ST_PLAY: begin
            if (w_tick) begin
               w_sreg_nxt   = {r_sreg[PATTERN_W-2:0], 1'b0};
               w_bitcnt_nxt = r_bitcnt - 4'd1;
               if (r_bitcnt == 4'd1) begin
                  w_gapcnt_nxt = GAP_LOAD;
                  w_state_nxt  = ST_GAP;
               end else begin
                  w_state_nxt  = ST_PLAY;
               end
            end else begin
               w_state_nxt = ST_PLAY;
            end
         end
         ST_GAP: begin
            if (w_tick) begin
               w_gapcnt_nxt = r_gapcnt - GW'(1);
               if (r_gapcnt == GW'(1)) begin
                  if (w_fifo_empty) w_state_nxt = ST_DONE;
                  else              w_state_nxt = ST_LOAD;
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end else begin
               w_state_nxt = ST_GAP;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase

      if (i_abort) begin
         w_state_nxt = ST_IDLE;
         w_pop       = 1'b0;
         w_flush     = 1'b1;
      end else begin
         w_flush     = 1'b0;
      end
   end

   // State, shift register and counters.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_sreg   <= {PATTERN_W{1'b0}};
         r_bitcnt <= 4'd0;
         r_gapcnt <= {GW{1'b0}};
         r_presc  <= PRESC_RELOAD;
      end else begin
         r_state  <= w_state_nxt;
         r_sreg   <= w_sreg_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_gapcnt <= w_gapcnt_nxt;
         r_presc  <= w_presc_nxt;
      end
   end

   // Outputs registered from the next state so they line up with the state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_out  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_out  <= (w_state_nxt == ST_PLAY) && w_sreg_nxt[PATTERN_W-1];
         r_busy <= (w_state_nxt != ST_IDLE);
         r_done <= (w_state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer with TICK_DIV=4, DEPTH=8, GAP_UNITS=3.
module tb_morse_sequencer;

   localparam int TD    = 4;
   localparam int GAP   = 3;
   localparam int DEPTH = 8;

   typedef struct { int letter; int first; int cut; } let_exp_t;
   typedef struct { int cyc; logic [4:0] val; logic [4:0] mask; } st_exp_t;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_letter;
   logic       start;
   logic       abort;
   logic       o_full, o_empty, o_busy, o_done, o_out;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   let_exp_t let_q[$];
   st_exp_t  st_q[$];
   int       done_q[$];
   int       mq[$];

   morse_sequencer #(.TICK_DIV(TD), .DEPTH(DEPTH), .GAP_UNITS(GAP)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_wr_en     (wr_en),
      .i_wr_letter (wr_letter),
      .i_start     (start),
      .i_abort     (abort),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_out       (o_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
   endtask

   // Expected per-cycle waveform derived from dot/dash notation.
   function automatic void build_wave(input int letter, output logic [127:0] w, output int len);
      string code;
      logic [15:0] units;
      int u;
      case (letter)
         0: code = "...";
         1: code = "-";
         2: code = "..-";
         3: code = "...-";
         4: code = ".--";
         5: code = "-..-";
         6: code = "-.--";
         7: code = "--..";
         default: code = "";
      endcase
      units = '0;
      u = 0;
      for (int i = 0; i < code.len(); i++) begin
         if (i > 0) begin units[u] = 1'b0; u++; end
         if (code[i] == "-") begin
            units[u] = 1'b1; units[u+1] = 1'b1; units[u+2] = 1'b1; u += 3;
         end else begin
            units[u] = 1'b1; u++;
         end
      end
      w = '0;
      len = u * TD;
      for (int j = 0; j < len; j++) w[j] = units[j / TD];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // bits: {busy, out, done, empty, full}; queue kept sorted by cycle
   task automatic expect_st(input int c, input logic [4:0] val, input logic [4:0] mask);
      st_exp_t e;
      int pos;
      e.cyc = c; e.val = val; e.mask = mask;
      pos = st_q.size();
      for (int i = 0; i < st_q.size(); i++) begin
         if (st_q[i].cyc > c) begin pos = i; break; end
      end
      st_q.insert(pos, e);
   endtask

   // Schedule a full message from the letters in mq, start pulse issued at cycle k.
   task automatic expect_msg(input int k);
      let_exp_t e;
      logic [127:0] w;
      int len, t;
      t = k + 2;
      while (mq.size() > 0) begin
         e.letter = mq.pop_front();
         e.first = t;
         e.cut = 0;
         let_q.push_back(e);
         expect_st(t - 1, 5'b10000, 5'b11100);
         build_wave(e.letter, w, len);
         t = t + len + GAP * TD + 1;
      end
      done_q.push_back(t - 1);
      expect_st(t - 1, 5'b10100, 5'b11100);
      expect_st(t, 5'b00010, 5'b11110);
   endtask

   task automatic push(input int l);
      wr_en = 1'b1;
      wr_letter = 3'(l);
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int n;
      n = 0;
      while (o_busy !== 1'b0 && n < maxc) begin step(); n++; end
      chk(o_busy === 1'b0, {name, "_idle"}, n, maxc);
      repeat (3) step();
   endtask

   // Letter monitor: rebuilds each letter from o_out and scores it.
   initial begin : letter_mon
      logic [127:0] rec, wave;
      int idx, last_high, low_run, first_cyc, len, n;
      bit in_letter, ok;
      let_exp_t e;
      in_letter = 0; idx = 0; last_high = 0; low_run = 0; first_cyc = 0;
      rec = '0;
      forever begin
         @(negedge clk);
         if (!in_letter && o_out === 1'b1) begin
            in_letter = 1; idx = 0; rec = '0; first_cyc = cyc; low_run = 0; last_high = 0;
         end
         if (in_letter) begin
            rec[idx] = o_out;
            if (o_out === 1'b1) begin last_high = idx; low_run = 0; end
            else low_run++;
            idx++;
            if (o_busy !== 1'b1 || low_run > TD || idx >= 127) begin
               in_letter = 0;
               if (let_q.size() == 0) begin
                  chk(1'b0, "letter_unexpected", first_cyc, -1);
               end else begin
                  e = let_q.pop_front();
                  build_wave(e.letter, wave, len);
                  chk(first_cyc == e.first, $sformatf("letter%0d_start", e.letter), first_cyc, e.first);
                  if (e.cut == 0) begin
                     chk(last_high + 1 == len, $sformatf("letter%0d_len", e.letter), last_high + 1, len);
                     ok = 1;
                     for (int i = 0; i < len; i++) if (rec[i] !== wave[i]) ok = 0;
                     chk(ok, $sformatf("letter%0d_bits", e.letter), longint'(rec[63:0]), longint'(wave[63:0]));
                  end else begin
                     n = e.cut - e.first;
                     ok = (cyc == e.cut) && (n >= 0) && (n < 127);
                     if (ok) begin
                        if (rec[n] !== 1'b0) ok = 0;
                        for (int i = 0; i < n; i++) if (rec[i] !== wave[i]) ok = 0;
                     end
                     chk(ok, $sformatf("letter%0d_abort", e.letter), cyc, e.cut);
                  end
               end
            end
         end
      end
   end

   // Done monitor: every done pulse must match a scheduled completion.
   initial begin : done_mon
      int e;
      forever begin
         @(negedge clk);
         if (o_done === 1'b1) begin
            if (done_q.size() == 0) begin
               chk(1'b0, "done_unexpected", cyc, -1);
            end else begin
               e = done_q.pop_front();
               chk(cyc == e, "done_cycle", cyc, e);
            end
         end
      end
   end

   // Status monitor: flag checks at scheduled cycles.
   initial begin : status_mon
      st_exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            e = st_q.pop_front();
            act = {o_busy, o_out, o_done, o_empty, o_full};
            if (e.cyc < cyc)
               chk(1'b0, $sformatf("status_missed_c%0d", e.cyc), cyc, e.cyc);
            else
               chk((act & e.mask) === (e.val & e.mask),
                   $sformatf("status_c%0d_mask%05b", e.cyc, e.mask),
                   longint'(act & e.mask), longint'(e.val & e.mask));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got cycle %0d, wanted completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int k, k2;
      let_exp_t e;
      rst = 1'b1; wr_en = 1'b0; wr_letter = 3'd0; start = 1'b0; abort = 1'b0;
      expect_st(2, 5'b00010, 5'b11111);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Single S
      push(0);
      mq = '{0};
      k = cyc; expect_msg(k); pulse_start();
      wait_idle(200, "msg_s");

      // T, Y, Z
      push(1); push(6); push(7);
      mq = '{1, 6, 7};
      k = cyc; expect_msg(k); pulse_start();
      wait_idle(600, "msg_tyz");

      // start while empty
      k = cyc;
      expect_st(k + 2, 5'b00000, 5'b10100);
      expect_st(k + 3, 5'b00010, 5'b10110);
      pulse_start();
      repeat (5) step();

      // DEPTH+1 pushes, last dropped
      for (int i = 0; i < DEPTH; i++) push(i);
      push(6);
      expect_st(cyc, 5'b00001, 5'b10011);
      step();
      mq = '{0, 1, 2, 3, 4, 5, 6, 7};
      k = cyc; expect_msg(k); pulse_start();
      wait_idle(1500, "msg_full");

      // push while full coinciding with the LOAD pop is accepted
      for (int i = DEPTH - 1; i >= 0; i--) push(i);
      mq = '{7, 6, 5, 4, 3, 2, 1, 0, 1};
      k = cyc; expect_msg(k);
      expect_st(k + 1, 5'b10001, 5'b10001);
      pulse_start();
      push(1);
      wait_idle(1500, "msg_pushpop");

      // abort mid-PLAY of W, with a simultaneous push that must be dropped
      push(4); push(1);
      k = cyc;
      e.letter = 4; e.first = k + 2; e.cut = k + 12;
      let_q.push_back(e);
      expect_st(k + 12, 5'b00010, 5'b11110);
      expect_st(k + 13, 5'b00010, 5'b11110);
      pulse_start();
      repeat (10) step();
      abort = 1'b1; wr_en = 1'b1; wr_letter = 3'd2;
      step();
      abort = 1'b0; wr_en = 1'b0;
      step();
      k2 = cyc;
      expect_st(k2 + 2, 5'b00010, 5'b10110);
      expect_st(k2 + 3, 5'b00000, 5'b10100);
      pulse_start();
      repeat (6) step();

      // X pushed during the gap after S plays with no DONE in between
      push(0);
      mq = '{0, 5};
      k = cyc; expect_msg(k); pulse_start();
      repeat (23) step();
      push(5);
      wait_idle(400, "msg_sx");

      // reset during the gap after S; queued T is lost
      push(0); push(1);
      k = cyc;
      e.letter = 0; e.first = k + 2; e.cut = 0;
      let_q.push_back(e);
      expect_st(k + 26, 5'b00010, 5'b11111);
      pulse_start();
      repeat (24) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      push(2);
      mq = '{2};
      k = cyc; expect_msg(k); pulse_start();
      wait_idle(300, "msg_after_reset");

      repeat (5) step();
      chk(let_q.size() == 0, "letters_outstanding", let_q.size(), 0);
      chk(done_q.size() == 0, "dones_outstanding", done_q.size(), 0);
      chk(st_q.size() == 0, "status_outstanding", st_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Message-level controller for the Morse letter datapath: buffers a queue of 3-bit letter codes (S..Z), loads each letter's 14-bit pattern into an internal shift register, and shifts it out one unit per prescaler tick. It inserts a fixed inter-letter gap and signals completion. It sits between the host logic (switch/key debouncing or a CPU-style writer) and the LED/buzzer output. It replaces the hand-driven start/load sequencing with a queued start/busy/done handshake.

## Interface
- TICK_DIV, 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- DEPTH, 8: letter queue depth; power of two.
- GAP_UNITS, 3: zero units inserted after each letter; must be ≥ 1.
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears queue, FSM, counters.
- wr_en  in  1  push wr_letter into the queue this cycle.
- wr_letter  in  3  letter code: 0=S, 1=T, 2=U, 3=V, 4=W, 5=X, 6=Y, 7=Z.
- start  in  1  single-cycle request to play the queued message.
- abort  in  1  stop playback and flush the queue.
- full  out  1  queue holds DEPTH letters.
- empty  out  1  queue holds no letters.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a message finishes normally.
- out  out  1  Morse output (1 = tone/LED on).

## Operation
- Patterns, MSB first, left-justified in 14 bits, with lengths (units): S 10101/5, T 111/3, U 1010111/7, V 101010111/9, W 101110111/9, X 11101010111/11, Y 1110101110111/13, Z 11101110101/11.
- Queue: FIFO. A push is accepted when not full, or when full and a pop occurs in the same cycle. A push while full without a pop is dropped silently. Pushes are accepted in any state, including during playback.
- FSM states:
  - IDLE: out=0. If start and not empty, go to LOAD. start while empty is ignored.
  - LOAD (1 cycle): pop the head letter; sreg ← pattern; bitcnt ← length; prescaler ← TICK_DIV−1. Go to PLAY.
  - PLAY: out = sreg[13]. On tick, shift sreg left by 1 and decrement bitcnt. On a tick with bitcnt==1, set gapcnt ← GAP_UNITS and go to GAP.
  - GAP: out=0. On tick, decrement gapcnt. On a tick with gapcnt==1: if not empty, go to LOAD; otherwise go to DONE.
  - DONE (1 cycle): done=1. Go to IDLE.
- abort has priority over everything except reset. From any state, next cycle is IDLE, the queue is flushed, out=0, and no done pulse is produced. A push in the same cycle as abort is discarded.
- Prescaler: down-counter. tick = (count==0). It reloads TICK_DIV−1 after reaching 0, and also in LOAD. Width is $clog2(TICK_DIV).

## Timing
- Reset values: out=0, busy=0, done=0, empty=1, full=0, FSM=IDLE.
- start sampled at edge t (IDLE, not empty): LOAD during cycle t+1, PLAY from t+2, first unit visible on out at t+2.
- Each unit lasts exactly TICK_DIV cycles. A letter of length L occupies L·TICK_DIV cycles in PLAY, followed by GAP_UNITS·TICK_DIV cycles in GAP.
- Letter-to-letter: the last GAP cycle is followed by a 1-cycle LOAD with out=0. The gap is therefore GAP_UNITS·TICK_DIV+1 cycles.
- Single-letter message total from start: 1 + 1 + (L+GAP_UNITS)·TICK_DIV cycles to DONE; done is high the cycle after the last GAP cycle.
- full/empty are registered and reflect push/pop effects one cycle after the edge.
- Reset mid-playback: next cycle all outputs take their reset values; queue contents are lost.

## Structure
- Package morse_pkg: letter code constants, 14-bit pattern ROM function, 4-bit length function, FSM state enum, PATTERN_W=14.
- Sub-module morse_fifo (DEPTH × 3-bit, push/pop/flush, full/empty). The prescaler, FSM, and shift register stay in morse_sequencer.

## Test plan
Run with TICK_DIV=4, GAP_UNITS=3.
- Reset, then push S and pulse start. out follows 1,0,1,0,1 units of 4 cycles each from start+2. Then 12 cycles of 0. done pulses at start+2+32.
- Push T,Y,Z and start. Each letter is bit-exact; the inter-letter low time is 13 cycles. busy stays high throughout, and a single done pulse follows the last letter.
- Pulse start while empty: busy stays 0, no done. Push DEPTH+1 letters: full=1, the last push is dropped, and the queue plays exactly DEPTH letters.
- Assert abort mid-PLAY of W: next cycle IDLE, out=0, empty=1, no done. A following start is ignored.
- Push X during GAP of S: X plays without a DONE in between. Push while full and a LOAD pop occur in the same cycle: the push is accepted.
- Assert reset mid-GAP: all outputs go to their reset values next cycle; a subsequent push+start plays normally.
